// File: rtl/wisc15_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wisc15_pkg
// Brief    : Shared widths, reset PC and fetch-stage types for the WISC-15 core
// Revision : 1.0
// ============================================================================
package wisc15_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALT   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory, execute-redirect and decode handshake bundle
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
    import wisc15_pkg::*;

    logic               im_req;
    logic [ADDR_W-1:0]  im_addr;
    logic               im_rvalid;
    logic [INSTR_W-1:0] im_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic [ADDR_W-1:0]  id_pc_plus1;
    logic               halted;

    modport master (
        output im_req, im_addr, id_valid, id_instr, id_pc, id_pc_plus1, halted,
        input  im_rvalid, im_rdata, redirect, redirect_pc, halt, id_ready
    );

    modport slave (
        input  im_req, im_addr, id_valid, id_instr, id_pc, id_pc_plus1, halted,
        output im_rvalid, im_rdata, redirect, redirect_pc, halt, id_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small synchronous FIFO with flush, occupancy count and head output
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : WISC-15 fetch front end: PC, credit-based issue, redirect squash
// Revision : 1.0
// ============================================================================
module fetch_stage
    import wisc15_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_squash_cnt;
    logic [CNT_W-1:0]  w_squash_nxt;
    logic [CNT_W-1:0]  w_buf_count;
    logic [CNT_W-1:0]  w_outstanding;
    logic [CNT_W:0]    w_credit;
    logic [ADDR_W-1:0] w_tag_head;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic              w_redirect;
    logic              w_pop;
    logic              w_retire;
    logic              w_push;
    logic              w_issue;

    assign w_redirect = bus.redirect && !bus.halt && (r_state != HALT);
    assign w_pop      = (w_buf_count != '0) && bus.id_ready && !w_redirect;
    assign w_retire   = bus.im_rvalid && (w_outstanding != '0);
    assign w_push     = w_retire && (r_squash_cnt == '0) && !w_redirect;

    // Buffered plus in-flight words may never exceed the buffer, so every
    // response is guaranteed a slot when it lands.
    assign w_credit = (CNT_W+1)'(w_buf_count) + (CNT_W+1)'(w_outstanding) - (CNT_W+1)'(w_pop);
    assign w_issue  = !rst && (r_state != HALT) && !bus.halt && !w_redirect &&
                      (w_credit < (CNT_W+1)'(BUF_DEPTH));

    assign w_push_entry = '{instr: bus.im_rdata, pc: w_tag_head};

    always_comb begin
        w_squash_nxt = r_squash_cnt;
        w_state_nxt  = r_state;
        if (w_redirect) begin
            w_squash_nxt = w_outstanding - CNT_W'(w_retire);
        end else if (w_retire && (r_squash_cnt != '0)) begin
            w_squash_nxt = r_squash_cnt - 1'b1;
        end
        case (r_state)
            RUN, SQUASH: begin
                if (bus.halt) begin
                    w_state_nxt = HALT;
                end else if (w_squash_nxt != '0) begin
                    w_state_nxt = SQUASH;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_fetch_pc   <= RESET_PC;
            r_squash_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_squash_cnt <= w_squash_nxt;
            if (w_redirect) begin
                r_fetch_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_entry_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (w_redirect),
        .o_count     (w_buf_count),
        .o_head      (w_head)
    );

    // Issue addresses of in-flight reads; its occupancy is the outstanding count.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (BUF_DEPTH)
    ) u_tag_q (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_issue),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_retire),
        .i_flush     (1'b0),
        .o_count     (w_outstanding),
        .o_head      (w_tag_head)
    );

    assign bus.im_req      = w_issue;
    assign bus.im_addr     = r_fetch_pc;
    assign bus.id_valid    = (w_buf_count != '0);
    assign bus.id_instr    = w_head.instr;
    assign bus.id_pc       = w_head.pc;
    assign bus.id_pc_plus1 = w_head.pc + 1'b1;
    assign bus.halted      = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Randomized bench for fetch_stage with stream scoreboard and memory model
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;
    import wisc15_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.BUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          stale_req = 0;
    int          stale_done = 0;
    logic [15:0] exp_q [$];
    mreq_t       pend [$];
    logic        req_s = 1'b0;
    logic [15:0] addr_s = '0;
    logic        m_halted;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_pc, prev_instr, mon_e;
    logic        mon_eff;
    mreq_t       mem_r;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Decode should see consecutive PCs from the latest fetch target onward.
    task automatic fill_stream(input logic [15:0] start);
        exp_q.delete();
        for (int i = 0; i < 2048; i++) exp_q.push_back(16'(start + 16'(i)));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_halted <= 1'b0;
        else if (bus.halt) m_halted <= 1'b1;
    end

    always @(negedge clk) begin
        req_s  = bus.im_req;
        addr_s = bus.im_addr;
    end

    // In-order instruction memory with per-request random latency.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            pend.delete();
            bus.im_rvalid = 1'b0;
            bus.im_rdata  = 16'h0;
        end else begin
            if (req_s) pend.push_back('{addr: addr_s, due: cyc + int'($urandom_range(lat_max, lat_min))});
            if (stale_req != stale_done) begin
                stale_done    = stale_req;
                bus.im_rvalid = 1'b1;
                bus.im_rdata  = 16'hDEAD;
            end else if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
                mem_r         = pend.pop_front();
                bus.im_rvalid = 1'b1;
                bus.im_rdata  = mem_word(mem_r.addr);
            end else begin
                bus.im_rvalid = 1'b0;
                bus.im_rdata  = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            mon_eff = bus.redirect && !bus.halt && !m_halted;
            if (prev_hold)
                chk(bus.id_valid && bus.id_pc == prev_pc && bus.id_instr == prev_instr, "hold_stable",
                    {bus.id_pc, bus.id_instr}, {prev_pc, prev_instr});
            if (bus.id_valid && bus.id_ready && !mon_eff) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "stream_underflow", 32'(bus.id_pc), 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk(bus.id_pc == mon_e && bus.id_instr == mem_word(mon_e) &&
                        bus.id_pc_plus1 == 16'(mon_e + 16'd1), "stream",
                        {bus.id_pc, bus.id_instr}, {mon_e, mem_word(mon_e)});
                end
                delivered++;
            end
            prev_hold  = bus.id_valid && !bus.id_ready && !mon_eff;
            prev_pc    = bus.id_pc;
            prev_instr = bus.id_instr;
            if (bus.halt || m_halted) chk(!bus.im_req, "no_issue_halt", 32'(bus.im_req), 32'h0);
            chk(bus.halted == m_halted, "halted", 32'(bus.halted), 32'(m_halted));
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.id_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.id_valid) chk(1'b0, name, 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        lat_min = 1;
        lat_max = 1;
        #1 chk(!bus.im_req && !bus.id_valid, "reset_immediate", 32'({bus.im_req, bus.id_valid}), 32'h0);
        fill_stream(RESET_PC);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale_req++;
    endtask

    // Entered just after reset release with 1-cycle memory and id_ready=1.
    task automatic startup_checks();
        @(negedge clk);
        chk(bus.im_req && bus.im_addr == RESET_PC, "first_req", 32'({bus.im_req, bus.im_addr}), 32'({1'b1, RESET_PC}));
        chk(!bus.id_valid && !bus.halted, "reset_state", 32'({bus.id_valid, bus.halted}), 32'h0);
        @(negedge clk);
        chk(!bus.id_valid && bus.im_addr == 16'(RESET_PC + 16'd1), "first_latency",
            32'({bus.id_valid, bus.im_addr}), 32'(16'(RESET_PC + 16'd1)));
        @(negedge clk);
        chk(bus.id_valid && bus.id_pc == RESET_PC, "first_pc", 32'({bus.id_valid, bus.id_pc}), 32'({1'b1, RESET_PC}));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int          d0;
        int          n;
        logic [15:0] rp;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.id_ready    = 1'b1;
        fill_stream(RESET_PC);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        stale_req++;
        startup_checks();

        @(posedge clk);
        #1 d0 = delivered;
        repeat (10) @(posedge clk);
        #1 chk(delivered - d0 == 10, "throughput", 32'(delivered - d0), 32'd10);

        bus.id_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk(!bus.im_req && bus.id_valid, "stall_credit", 32'({bus.im_req, bus.id_valid}), 32'h1);
        bus.id_ready = 1'b1;

        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (pend.size() != 2 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk(pend.size() == 2, "t3_inflight", 32'(pend.size()), 32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        fill_stream(16'h0040);
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        @(negedge clk);
        wait_valid("t3_timeout");
        chk(bus.id_pc == 16'h0040 && bus.id_pc_plus1 == 16'h0041, "t3_target",
            {bus.id_pc, bus.id_pc_plus1}, 32'h0040_0041);

        @(posedge clk);
        #1 bus.redirect = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        fill_stream(16'hFFFF);
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        @(negedge clk);
        wait_valid("t4_timeout");
        chk(bus.id_pc == 16'hFFFF && bus.id_pc_plus1 == 16'h0000, "t4_wrap",
            {bus.id_pc, bus.id_pc_plus1}, 32'hFFFF_0000);
        @(negedge clk);
        wait_valid("t4_timeout_next");
        chk(bus.id_pc == 16'h0000, "t4_wrap_next", 32'(bus.id_pc), 32'h0);

        lat_min = 1;
        lat_max = 3;
        repeat (800) begin
            @(posedge clk);
            #1 bus.id_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(39, 0) == 0) begin
                rp              = 16'($urandom);
                bus.redirect    = 1'b1;
                bus.redirect_pc = rp;
                fill_stream(rp);
            end else begin
                bus.redirect = 1'b0;
            end
        end
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        bus.id_ready = 1'b1;

        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (pend.size() == 0 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk(pend.size() != 0, "t6_inflight", 32'(pend.size()), 32'd1);
        do_reset();
        startup_checks();

        repeat (200) begin
            @(posedge clk);
            #1 bus.id_ready = ($urandom_range(3, 0) != 0);
        end

        lat_min = 1;
        lat_max = 1;
        @(posedge clk);
        #1 bus.id_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.halt = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h1234;
        @(posedge clk);
        #1 bus.halt = 1'b0;
        bus.redirect = 1'b0;
        d0 = delivered;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk(bus.halted, "t5_halted", 32'(bus.halted), 32'h1);
        repeat (10) @(posedge clk);
        #1 chk(delivered - d0 == 2, "t5_drain", 32'(delivered - d0), 32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h2222;
        @(posedge clk);
        #1 bus.redirect = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk(!bus.id_valid && !bus.im_req, "t5_redirect_ignored", 32'({bus.id_valid, bus.im_req}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
